seq_mult8: RTL and testbench



---
 rtl/seq_mult8_pkg.sv | 35 +++
 rtl/array4.sv | 10 +
 rtl/seq_mult8.sv | 112 +++++++++++
 tb/tb_seq_mult8.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult8_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier.
package seq_mult8_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;

    localparam logic [3:0] SHIFT_PP0 = 4'd0;
    localparam logic [3:0] SHIFT_PP1 = 4'd4;
    localparam logic [3:0] SHIFT_PP2 = 4'd4;
    localparam logic [3:0] SHIFT_PP3 = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StPp0,
        StPp1,
        StPp2,
        StPp3,
        StDone
    } mult_state_t;

    // Left shift applied to the partial product produced in a given state.
    function automatic logic [3:0] pp_shift(input mult_state_t st);
        logic [3:0] sh;
        sh = SHIFT_PP0;
        case (st)
            StPp1:   sh = SHIFT_PP1;
            StPp2:   sh = SHIFT_PP2;
            StPp3:   sh = SHIFT_PP3;
            default: sh = SHIFT_PP0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/array4.sv
// Existing combinational 4x4 unsigned array multiplier.
module array4 (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [7:0] Z
);

    assign Z = {4'b0000, X} * {4'b0000, Y};

endmodule

// File: rtl/seq_mult8.sv
// 8x8 unsigned multiplier that reuses one array4 across four nibble-pair cycles,
// with valid/ready handshakes on operand and result sides.
module seq_mult8
    import seq_mult8_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PROD_W-1:0] p_o,
    output logic              busy_o
);

    mult_state_t         state_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [PROD_W-1:0]   acc_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [NIB_W-1:0]    x_nib;
    logic [NIB_W-1:0]    y_nib;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_shifted;
    logic [PROD_W-1:0]   acc_sum;

    // Nibble selects come only from registered operands, never from the input ports.
    always_comb begin
        x_nib = a_q[NIB_W-1:0];
        y_nib = b_q[NIB_W-1:0];
        case (state_q)
            StPp1: x_nib = a_q[OP_W-1:NIB_W];
            StPp2: y_nib = b_q[OP_W-1:NIB_W];
            StPp3: begin
                x_nib = a_q[OP_W-1:NIB_W];
                y_nib = b_q[OP_W-1:NIB_W];
            end
            default: ;
        endcase
    end

    array4 u_array4 (
        .X (x_nib),
        .Y (y_nib),
        .Z (pp)
    );

    assign pp_shifted = {{(PROD_W - 2*NIB_W){1'b0}}, pp} << pp_shift(state_q);
    assign acc_sum    = acc_q + pp_shifted;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        acc_q   <= '0;
                        state_q <= StPp0;
                        busy_q  <= 1'b1;
                    end
                end
                StPp0: begin
                    acc_q   <= pp_shifted;
                    state_q <= StPp1;
                end
                StPp1: begin
                    acc_q   <= acc_sum;
                    state_q <= StPp2;
                end
                StPp2: begin
                    acc_q   <= acc_sum;
                    state_q <= StPp3;
                end
                StPp3: begin
                    acc_q       <= acc_sum;
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign p_o         = acc_q;

endmodule

// File: tb/tb_seq_mult8.sv
// Directed and randomised self-checking bench for seq_mult8.
module tb_seq_mult8;

    logic        clk_i       = 1'b0;
    logic        rst_ni      = 1'b0;
    logic        in_valid_i  = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_i         = 8'h00;
    logic [7:0]  b_i         = 8'h00;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] p_o;
    logic        busy_o;

    int checks  = 0;
    int errors  = 0;
    int cycle_n = 0;

    seq_mult8 dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .p_o         (p_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
        cycle_n++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
        checks++; if (p_o !== 16'h0000) begin errors++; $display("FAIL reset_p got %h exp 0000", p_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got rdy=%b busy=%b exp rdy=1 busy=0", in_ready_o, busy_o);
        end
    endtask

    task automatic test_single();
        a_i = 8'hFF; b_i = 8'hFF; in_valid_i = 1'b1; out_ready_i = 1'b1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_pre got %b exp 1", in_ready_o); end
        cyc();
        in_valid_i = 1'b0;
        checks++; if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL single_accept got rdy=%b busy=%b exp rdy=0 busy=1", in_ready_o, busy_o);
        end
        repeat (3) begin
            cyc();
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid_o); end
        end
        cyc();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1", out_valid_o); end
        checks++; if (p_o !== 16'hFE01) begin errors++; $display("FAIL single_p got %h exp fe01", p_o); end
        cyc();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL single_return_idle got v=%b rdy=%b busy=%b exp 0 1 0", out_valid_o, in_ready_o, busy_o);
        end
    endtask

    task automatic test_stall();
        out_ready_i = 1'b0;
        a_i = 8'h0F; b_i = 8'hF0; in_valid_i = 1'b1;
        cyc();
        in_valid_i = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid_o !== 1'b1 || p_o !== 16'h0E10) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b p=%h exp v=1 p=0e10", i, out_valid_o, p_o);
            end
            if (i < 5) cyc();
        end
        out_ready_i = 1'b1;
        cyc();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_corrupt();
        out_ready_i = 1'b1;
        a_i = 8'h12; b_i = 8'h34; in_valid_i = 1'b1;
        cyc();
        a_i = 8'hFF; b_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++; $display("FAIL corrupt_busy[%0d] got rdy=%b busy=%b exp rdy=0 busy=1", i, in_ready_o, busy_o);
            end
            cyc();
        end
        checks++; if (out_valid_o !== 1'b1 || p_o !== 16'h03A8) begin
            errors++; $display("FAIL corrupt_p got v=%b p=%h exp v=1 p=03a8", out_valid_o, p_o);
        end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL corrupt_done_ready got %b exp 0", in_ready_o); end
        cyc();
        in_valid_i = 1'b0;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL corrupt_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [4] = '{8'd3, 8'd0, 8'd255, 8'd128};
        logic [7:0]  tb [4] = '{8'd5, 8'd200, 8'd1, 8'd2};
        logic [15:0] tp [4] = '{16'h000F, 16'h0000, 16'h00FF, 16'h0100};
        int t_prev = 0;
        int w;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_i = ta[i]; b_i = tb[i]; in_valid_i = 1'b1;
            checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready_o); end
            cyc();
            w = 0;
            while (out_valid_o !== 1'b1 && w < 8) begin
                cyc();
                w++;
            end
            checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_timeout[%0d] got v=%b exp 1", i, out_valid_o); end
            checks++; if (p_o !== tp[i]) begin errors++; $display("FAIL b2b_p[%0d] got %h exp %h", i, p_o, tp[i]); end
            if (i > 0) begin
                checks++; if (cycle_n - t_prev != 6) begin
                    errors++; $display("FAIL b2b_period[%0d] got %0d exp 6", i, cycle_n - t_prev);
                end
            end
            t_prev = cycle_n;
            cyc();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b1;
        a_i = 8'hAB; b_i = 8'hCD; in_valid_i = 1'b1;
        cyc();
        in_valid_i = 1'b0;
        repeat (2) cyc();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || p_o !== 16'h0000) begin
            errors++; $display("FAIL midreset_async got v=%b busy=%b p=%h exp 0 0 0000", out_valid_o, busy_o, p_o);
        end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", in_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        a_i = 8'h02; b_i = 8'h03; in_valid_i = 1'b1;
        cyc();
        in_valid_i = 1'b0;
        repeat (3) begin
            cyc();
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_early got %b exp 0", out_valid_o); end
        end
        cyc();
        checks++; if (out_valid_o !== 1'b1 || p_o !== 16'h0006) begin
            errors++; $display("FAIL midreset_new_op got v=%b p=%h exp v=1 p=0006", out_valid_o, p_o);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [15:0] e;
        int sent  = 0;
        int got   = 0;
        int guard = 0;
        int extra = 0;
        logic take;
        in_valid_i = 1'b0;
        while (got < 500 && guard < 20000) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected got %h exp none", p_o);
                end else begin
                    e = exp_q.pop_front();
                    if (p_o !== e) begin errors++; $display("FAIL rand_p[%0d] got %h exp %h", got, p_o, e); end
                end
                got++;
            end
            if (!in_valid_i && sent < 500 && $urandom_range(0, 2) != 0) begin
                a_i = 8'($urandom); b_i = 8'($urandom); in_valid_i = 1'b1;
            end
            take = in_valid_i && in_ready_o;
            if (take) begin
                exp_q.push_back({8'h00, a_i} * {8'h00, b_i});
                sent++;
            end
            cyc();
            guard++;
            if (take) begin
                in_valid_i = 1'b0;
                a_i = 8'($urandom); b_i = 8'($urandom);
            end
        end
        checks++; if (got != 500) begin errors++; $display("FAIL rand_count got %0d exp 500", got); end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (10) begin
            if (out_valid_o) extra++;
            cyc();
        end
        checks++; if (extra != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_leftover got extra=%0d pending=%0d exp 0 0", extra, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_corrupt();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
